pipe_buf_mw: RTL and testbench

PIPE_BUF_MW -- requirements
Module: pipe_buf_mw

---
 rtl/pipe_buf_mw.sv | 140 ++++++++++++++
 tb/tb_pipe_buf_mw.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_buf_mw.sv
// rtl/pipe_buf_mw.sv - M-to-W pipeline buffer of DEPTH stages with writeback mux and forwarding lookup
// Optional performance counters are compiled in with `define PIPE_BUF_MW_PERF_EN.
module pipe_buf_mw #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_M,
  input  logic [1:0]      sel_wb_M,
  input  logic            rf_en_M,
  input  logic [XLEN-1:0] inst_M,
  input  logic [XLEN-1:0] pc_M,
  input  logic [XLEN-1:0] alu_out_M,
  input  logic [XLEN-1:0] out_data_M,
  output logic            valid_W,
  output logic            rf_en_W,
  output logic [1:0]      sel_wb_W,
  output logic [4:0]      rd_W,
  output logic [XLEN-1:0] inst_W,
  output logic [XLEN-1:0] pc_W,
  output logic [XLEN-1:0] alu_out_W,
  output logic [XLEN-1:0] out_data_W,
  output logic [XLEN-1:0] wb_data_W,
  input  logic [4:0]      fwd_rs,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data
`ifdef PIPE_BUF_MW_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_rf_en;
  logic [1:0]       r_sel_wb   [DEPTH];
  logic [XLEN-1:0]  r_inst     [DEPTH];
  logic [XLEN-1:0]  r_pc       [DEPTH];
  logic [XLEN-1:0]  r_alu_out  [DEPTH];
  logic [XLEN-1:0]  r_out_data [DEPTH];

  logic            w_fwd_hit;
  logic [XLEN-1:0] w_fwd_data;

  function automatic logic [XLEN-1:0] f_wb_sel(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] mem
  );
    logic [XLEN-1:0] v;
    case (sel)
      2'b00:   v = pc + XLEN'(4);
      2'b01:   v = alu;
      2'b10:   v = mem;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Reset and flush both zero the whole chain; stall only holds when no flush is pending.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
      r_rf_en <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_sel_wb[k]   <= 2'b00;
        r_inst[k]     <= '0;
        r_pc[k]       <= '0;
        r_alu_out[k]  <= '0;
        r_out_data[k] <= '0;
      end
    end else if (!stall) begin
      r_valid[0]    <= valid_M;
      r_rf_en[0]    <= rf_en_M;
      r_sel_wb[0]   <= sel_wb_M;
      r_inst[0]     <= inst_M;
      r_pc[0]       <= pc_M;
      r_alu_out[0]  <= alu_out_M;
      r_out_data[0] <= out_data_M;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k]    <= r_valid[k-1];
        r_rf_en[k]    <= r_rf_en[k-1];
        r_sel_wb[k]   <= r_sel_wb[k-1];
        r_inst[k]     <= r_inst[k-1];
        r_pc[k]       <= r_pc[k-1];
        r_alu_out[k]  <= r_alu_out[k-1];
        r_out_data[k] <= r_out_data[k-1];
      end
    end
  end

  // Scan oldest to newest so the stage nearest M (youngest producer) wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (r_valid[k] && r_rf_en[k] && (r_inst[k][11:7] == fwd_rs) && (fwd_rs != 5'd0)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = f_wb_sel(r_sel_wb[k], r_pc[k], r_alu_out[k], r_out_data[k]);
      end
    end
  end

  assign valid_W    = r_valid[DEPTH-1];
  assign rf_en_W    = r_rf_en[DEPTH-1] & r_valid[DEPTH-1];
  assign sel_wb_W   = r_sel_wb[DEPTH-1];
  assign inst_W     = r_inst[DEPTH-1];
  assign rd_W       = r_inst[DEPTH-1][11:7];
  assign pc_W       = r_pc[DEPTH-1];
  assign alu_out_W  = r_alu_out[DEPTH-1];
  assign out_data_W = r_out_data[DEPTH-1];
  assign wb_data_W  = f_wb_sel(r_sel_wb[DEPTH-1], r_pc[DEPTH-1], r_alu_out[DEPTH-1], r_out_data[DEPTH-1]);
  assign fwd_hit    = w_fwd_hit;
  assign fwd_data   = w_fwd_data;

`ifdef PIPE_BUF_MW_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall && !flush && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_buf_mw.sv
// tb/tb_pipe_buf_mw.sv - directed bench for pipe_buf_mw at DEPTH 1, 2 and 3
module tb_pipe_buf_mw;
  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_M, rf_en_M;
  logic [1:0]  sel_wb_M;
  logic [31:0] inst_M, pc_M, alu_out_M, out_data_M;
  logic [4:0]  fwd_rs;

  logic        d1_valid, d1_rf_en, d1_hit, d2_valid, d2_rf_en, d2_hit, d3_valid, d3_rf_en, d3_hit;
  logic [1:0]  d1_sel, d2_sel, d3_sel;
  logic [4:0]  d1_rd, d2_rd, d3_rd;
  logic [31:0] d1_inst, d1_pc, d1_alu, d1_od, d1_wb, d1_fd;
  logic [31:0] d2_inst, d2_pc, d2_alu, d2_od, d2_wb, d2_fd;
  logic [31:0] d3_inst, d3_pc, d3_alu, d3_od, d3_wb, d3_fd;
`ifdef PIPE_BUF_MW_PERF_EN
  logic [31:0] d1_sc, d1_fc, d2_sc, d2_fc, d3_sc, d3_fc;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipe_buf_mw #(.XLEN(32), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_M(valid_M), .sel_wb_M(sel_wb_M),
    .rf_en_M(rf_en_M), .inst_M(inst_M), .pc_M(pc_M), .alu_out_M(alu_out_M), .out_data_M(out_data_M),
    .valid_W(d1_valid), .rf_en_W(d1_rf_en), .sel_wb_W(d1_sel), .rd_W(d1_rd), .inst_W(d1_inst),
    .pc_W(d1_pc), .alu_out_W(d1_alu), .out_data_W(d1_od), .wb_data_W(d1_wb),
    .fwd_rs(fwd_rs), .fwd_hit(d1_hit), .fwd_data(d1_fd)
`ifdef PIPE_BUF_MW_PERF_EN
    , .stall_cnt(d1_sc), .flush_cnt(d1_fc)
`endif
  );

  pipe_buf_mw #(.XLEN(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_M(valid_M), .sel_wb_M(sel_wb_M),
    .rf_en_M(rf_en_M), .inst_M(inst_M), .pc_M(pc_M), .alu_out_M(alu_out_M), .out_data_M(out_data_M),
    .valid_W(d2_valid), .rf_en_W(d2_rf_en), .sel_wb_W(d2_sel), .rd_W(d2_rd), .inst_W(d2_inst),
    .pc_W(d2_pc), .alu_out_W(d2_alu), .out_data_W(d2_od), .wb_data_W(d2_wb),
    .fwd_rs(fwd_rs), .fwd_hit(d2_hit), .fwd_data(d2_fd)
`ifdef PIPE_BUF_MW_PERF_EN
    , .stall_cnt(d2_sc), .flush_cnt(d2_fc)
`endif
  );

  pipe_buf_mw #(.XLEN(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_M(valid_M), .sel_wb_M(sel_wb_M),
    .rf_en_M(rf_en_M), .inst_M(inst_M), .pc_M(pc_M), .alu_out_M(alu_out_M), .out_data_M(out_data_M),
    .valid_W(d3_valid), .rf_en_W(d3_rf_en), .sel_wb_W(d3_sel), .rd_W(d3_rd), .inst_W(d3_inst),
    .pc_W(d3_pc), .alu_out_W(d3_alu), .out_data_W(d3_od), .wb_data_W(d3_wb),
    .fwd_rs(fwd_rs), .fwd_hit(d3_hit), .fwd_data(d3_fd)
`ifdef PIPE_BUF_MW_PERF_EN
    , .stall_cnt(d3_sc), .flush_cnt(d3_fc)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_m;
    valid_M = 0; rf_en_M = 0; sel_wb_M = 2'b00;
    inst_M = 0; pc_M = 0; alu_out_M = 0; out_data_M = 0;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] od);
    valid_M = 1; rf_en_M = 1; sel_wb_M = sel;
    inst_M = inst; pc_M = pc; alu_out_M = alu; out_data_M = od;
  endtask

  task automatic do_reset;
    rst = 1; stall = 0; flush = 0; fwd_rs = 0;
    clear_m();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (d1_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", d1_valid); else passed++;
    total++; if (d1_rf_en !== 1'b0) $display("FAIL reset_rf_en got %b want 0", d1_rf_en); else passed++;
    total++; if (d1_rd !== 5'd0) $display("FAIL reset_rd got %0d want 0", d1_rd); else passed++;
    total++; if (d1_sel !== 2'b00) $display("FAIL reset_sel got %b want 00", d1_sel); else passed++;
    total++; if (d2_inst !== 32'h0 || d2_pc !== 32'h0 || d2_alu !== 32'h0 || d2_od !== 32'h0)
      $display("FAIL reset_payload got %h %h %h %h want 0", d2_inst, d2_pc, d2_alu, d2_od); else passed++;
    total++; if (d3_wb !== 32'h4) $display("FAIL reset_wb_data got %h want 00000004", d3_wb); else passed++;
    fwd_rs = 5'd1; #1;
    total++; if (d2_hit !== 1'b0 || d2_fd !== 32'h0) $display("FAIL reset_fwd got %b %h want 0 0", d2_hit, d2_fd); else passed++;
    fwd_rs = 5'd0;
  endtask

  task automatic test_depth1;
    do_reset();
    drive(2'b01, 32'h00A00093, 32'h0, 32'h10, 32'h0);
    tick();
    total++; if (d1_rd !== 5'd1) $display("FAIL d1_rd got %0d want 1", d1_rd); else passed++;
    total++; if (d1_rf_en !== 1'b1) $display("FAIL d1_rf_en got %b want 1", d1_rf_en); else passed++;
    total++; if (d1_wb !== 32'h10) $display("FAIL d1_wb_data got %h want 00000010", d1_wb); else passed++;
    sel_wb_M = 2'b10; out_data_M = 32'hCAFE0001;
    tick();
    total++; if (d1_wb !== 32'hCAFE0001) $display("FAIL d1_wb_mem got %h want cafe0001", d1_wb); else passed++;
    sel_wb_M = 2'b11; rf_en_M = 0;
    tick();
    total++; if (d1_wb !== 32'h0 || d1_rf_en !== 1'b0) $display("FAIL d1_wb_zero got %h %b want 0 0", d1_wb, d1_rf_en); else passed++;
    sel_wb_M = 2'b00; pc_M = 32'hFFFF_FFFC; rf_en_M = 1; valid_M = 0;
    tick();
    total++; if (d1_wb !== 32'h0 || d1_rf_en !== 1'b0) $display("FAIL d1_pc_wrap_invalid got %h %b want 0 0", d1_wb, d1_rf_en); else passed++;
    clear_m();
  endtask

  task automatic test_latency3;
    do_reset();
    valid_M = 1; sel_wb_M = 2'b00; pc_M = 32'h100;
    tick();
    clear_m();
    total++; if (d3_wb !== 32'h4 || d3_valid !== 1'b0) $display("FAIL d3_cycle1 got %h %b want 00000004 0", d3_wb, d3_valid); else passed++;
    tick();
    total++; if (d3_wb !== 32'h4 || d3_valid !== 1'b0) $display("FAIL d3_cycle2 got %h %b want 00000004 0", d3_wb, d3_valid); else passed++;
    tick();
    total++; if (d3_wb !== 32'h104 || d3_valid !== 1'b1) $display("FAIL d3_cycle3 got %h %b want 00000104 1", d3_wb, d3_valid); else passed++;
    tick();
    total++; if (d3_valid !== 1'b0) $display("FAIL d3_cycle4 got %b want 0", d3_valid); else passed++;
  endtask

  task automatic test_stall;
    do_reset();
    drive(2'b01, 32'h00000293, 32'h200, 32'hAA, 32'h0);
    tick();
    total++; if (d1_alu !== 32'hAA) $display("FAIL stall_load got %h want 000000aa", d1_alu); else passed++;
    stall = 1;
    drive(2'b01, 32'h00000313, 32'h204, 32'hBB, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (d1_alu !== 32'hAA || d1_pc !== 32'h200 || d1_rd !== 5'd5)
        $display("FAIL stall_hold%0d got %h %h %0d want 000000aa 00000200 5", i, d1_alu, d1_pc, d1_rd); else passed++;
    end
    stall = 0;
    tick();
    total++; if (d1_alu !== 32'hBB || d1_rd !== 5'd6) $display("FAIL stall_release got %h %0d want 000000bb 6", d1_alu, d1_rd); else passed++;
    clear_m();
  endtask

  task automatic test_stall_flush;
    do_reset();
    drive(2'b01, 32'h00000293, 32'h300, 32'h55, 32'h0);
    tick();
    stall = 1; flush = 1;
    tick();
    stall = 0; flush = 0;
    clear_m();
    total++; if (d1_valid !== 1'b0 || d1_rf_en !== 1'b0 || d1_inst !== 32'h0)
      $display("FAIL stall_flush got %b %b %h want 0 0 0", d1_valid, d1_rf_en, d1_inst); else passed++;
    total++; if (d1_wb !== 32'h4) $display("FAIL stall_flush_wb got %h want 00000004", d1_wb); else passed++;
  endtask

  task automatic test_forward;
    do_reset();
    drive(2'b01, 32'h00000293, 32'h400, 32'h11, 32'h0);
    tick();
    drive(2'b01, 32'h00000293, 32'h404, 32'h22, 32'h0);
    tick();
    clear_m();
    fwd_rs = 5'd5; #1;
    total++; if (d2_hit !== 1'b1 || d2_fd !== 32'h22) $display("FAIL fwd_newest got %b %h want 1 00000022", d2_hit, d2_fd); else passed++;
    total++; if (d2_wb !== 32'h11 || d2_rf_en !== 1'b1) $display("FAIL fwd_w_stage got %h %b want 00000011 1", d2_wb, d2_rf_en); else passed++;
    fwd_rs = 5'd0; #1;
    total++; if (d2_hit !== 1'b0 || d2_fd !== 32'h0) $display("FAIL fwd_x0 got %b %h want 0 0", d2_hit, d2_fd); else passed++;
    fwd_rs = 5'd6; #1;
    total++; if (d2_hit !== 1'b0 || d2_fd !== 32'h0) $display("FAIL fwd_miss got %b %h want 0 0", d2_hit, d2_fd); else passed++;
    fwd_rs = 5'd5;
    tick();
    total++; if (d2_hit !== 1'b1 || d2_fd !== 32'h22) $display("FAIL fwd_older_stage got %b %h want 1 00000022", d2_hit, d2_fd); else passed++;
    fwd_rs = 5'd0;
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive(2'b01, 32'h00000293, 32'h500, 32'h31, 32'h0);
    tick();
    alu_out_M = 32'h32;
    tick();
    alu_out_M = 32'h33;
    rst = 1;
    tick();
    rst = 0;
    clear_m();
    total++; if (d3_valid !== 1'b0 || d3_rf_en !== 1'b0 || d3_rd !== 5'd0 || d3_sel !== 2'b00)
      $display("FAIL midrst_ctrl got %b %b %0d %b want 0 0 0 00", d3_valid, d3_rf_en, d3_rd, d3_sel); else passed++;
    total++; if (d3_inst !== 32'h0 || d3_alu !== 32'h0 || d3_pc !== 32'h0 || d3_wb !== 32'h4)
      $display("FAIL midrst_data got %h %h %h %h want 0 0 0 00000004", d3_inst, d3_alu, d3_pc, d3_wb); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (d3_rf_en !== 1'b0 || d3_valid !== 1'b0) $display("FAIL midrst_drain%0d got %b %b want 0 0", i, d3_rf_en, d3_valid); else passed++;
    end
  endtask

`ifdef PIPE_BUF_MW_PERF_EN
  task automatic test_perf;
    do_reset();
    stall = 1;
    for (int i = 0; i < 3; i++) tick();
    stall = 0;
    total++; if (d1_sc !== 32'd3 || d1_fc !== 32'd0) $display("FAIL perf_stall got %0d %0d want 3 0", d1_sc, d1_fc); else passed++;
    stall = 1; flush = 1;
    tick();
    stall = 0; flush = 0;
    total++; if (d1_sc !== 32'd3 || d1_fc !== 32'd1) $display("FAIL perf_flush got %0d %0d want 3 1", d1_sc, d1_fc); else passed++;
    do_reset();
    total++; if (d1_sc !== 32'd0 || d1_fc !== 32'd0) $display("FAIL perf_rst got %0d %0d want 0 0", d1_sc, d1_fc); else passed++;
  endtask
`endif

  initial begin
    rst = 1; stall = 0; flush = 0; fwd_rs = 0;
    clear_m();
    test_reset();
    test_depth1();
    test_latency3();
    test_stall();
    test_stall_flush();
    test_forward();
    test_reset_mid();
`ifdef PIPE_BUF_MW_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
